hls_phi_add: RTL and testbench

HLS_PHI_ADD -- requirements
Module: hls_phi_add

---
 rtl/hls_phi_add.sv | 98 +++++++++
 tb/tb_hls_phi_add.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hls_phi_add.sv
// hls_phi_add: last-block register, phi selector and independent adder.
// The phi selector picks the value of the lowest-indexed pair whose block id
// matches the registered last_block. Zero is the fallback when no id matches.
// Optional macro HLS_PHI_ADD_OUTREG_EN registers phi_out, phi_hit and add_out,
// which adds one cycle of latency. The default build leaves them combinational.

// Branch block with no ports and no logic; present for hierarchy elaboration.
module br_dummy;
endmodule

module hls_phi_add #(
  parameter int WIDTH   = 32,
  parameter int NB_PAIR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              bb_id,
  input  logic                     bb_commit,
  output logic [31:0]              last_block,
  input  logic [NB_PAIR*WIDTH-1:0] phi_in,
  input  logic [NB_PAIR*32-1:0]    phi_s,
  output logic [WIDTH-1:0]         phi_out,
  output logic                     phi_hit,
  input  logic [WIDTH-1:0]         add_in0,
  input  logic [WIDTH-1:0]         add_in1,
  output logic [WIDTH-1:0]         add_out
);

  logic [31:0]        last_block_q, last_block_d;
  logic [NB_PAIR-1:0] match;
  logic [WIDTH-1:0]   phi_out_d;
  logic               phi_hit_d;
  logic [WIDTH-1:0]   add_out_d;

  br_dummy u_br_dummy ();

  // Next last-block value: load on commit, otherwise hold.
  always_comb begin
    last_block_d = last_block_q;
    if (bb_commit) last_block_d = bb_id;
  end

  // Last-block register. Reset takes priority over commit.
  always_ff @(posedge clk) begin
    if (rst) last_block_q <= '0;
    else     last_block_q <= last_block_d;
  end

  assign last_block = last_block_q;

  // Per-pair comparators. They only see the registered block id.
  for (genvar g = 0; g < NB_PAIR; g++) begin : g_match
    assign match[g] = (phi_s[g*32 +: 32] == last_block_q);
  end

  // Priority pick. Scanning downward means the lowest matching index is written last and wins.
  always_comb begin
    phi_out_d = '0;
    phi_hit_d = 1'b0;
    for (int i = NB_PAIR - 1; i >= 0; i--) begin
      if (match[i]) begin
        phi_out_d = phi_in[i*WIDTH +: WIDTH];
        phi_hit_d = 1'b1;
      end
    end
  end

  // Wrapping unsigned add. The carry is dropped.
  always_comb add_out_d = add_in0 + add_in1;

`ifdef HLS_PHI_ADD_OUTREG_EN
  logic [WIDTH-1:0] phi_out_q;
  logic             phi_hit_q;
  logic [WIDTH-1:0] add_out_q;

  // Output registers add one cycle of latency on every result path.
  always_ff @(posedge clk) begin
    if (rst) begin
      phi_out_q <= '0;
      phi_hit_q <= 1'b0;
      add_out_q <= '0;
    end else begin
      phi_out_q <= phi_out_d;
      phi_hit_q <= phi_hit_d;
      add_out_q <= add_out_d;
    end
  end

  assign phi_out = phi_out_q;
  assign phi_hit = phi_hit_q;
  assign add_out = add_out_q;
`else
  assign phi_out = phi_out_d;
  assign phi_hit = phi_hit_d;
  assign add_out = add_out_d;
`endif

endmodule

// File: tb/tb_hls_phi_add.sv
// Bench for hls_phi_add (WIDTH=8, NB_PAIR=2). It runs table vectors with a scoreboard queue,
// plus hand-written sequences for reset, the pre-edge commit and the reset/commit collision.
module tb_hls_phi_add;
  localparam int W  = 8;
  localparam int NP = 2;
`ifdef HLS_PHI_ADD_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       bb_id;
  logic              bb_commit;
  logic [31:0]       last_block;
  logic [NP*W-1:0]   phi_in;
  logic [NP*32-1:0]  phi_s;
  logic [W-1:0]      phi_out;
  logic              phi_hit;
  logic [W-1:0]      add_in0, add_in1, add_out;

  hls_phi_add #(.WIDTH(W), .NB_PAIR(NP)) dut (
    .clk(clk), .rst(rst), .bb_id(bb_id), .bb_commit(bb_commit),
    .last_block(last_block), .phi_in(phi_in), .phi_s(phi_s),
    .phi_out(phi_out), .phi_hit(phi_hit),
    .add_in0(add_in0), .add_in1(add_in1), .add_out(add_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] last;
    logic [W-1:0] out;
    logic         hit;
    logic [W-1:0] add;
  } exp_t;

  typedef struct {
    logic         commit;
    logic [31:0]  id;
    logic [63:0]  s;
    logic [15:0]  pin;
    logic [W-1:0] a0, a1;
    exp_t         e;
  } vec_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_check(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d_last_block", idx), last_block, e.last);
      chk($sformatf("v%0d_phi_out", idx), {24'd0, phi_out}, {24'd0, e.out});
      chk($sformatf("v%0d_phi_hit", idx), {31'd0, phi_hit}, {31'd0, e.hit});
      chk($sformatf("v%0d_add_out", idx), {24'd0, add_out}, {24'd0, e.add});
    end
  endtask

  initial begin
    //               commit id     phi_s {p1,p0}        phi_in  a0     a1     {last, out,   hit, add}
    vecs[0] = '{1'b1, 32'd1, {32'd1, 32'd0}, 16'h2A00, 8'hFF, 8'h01, '{32'd1, 8'h2A, 1'b1, 8'h00}};
    vecs[1] = '{1'b1, 32'd7, {32'd1, 32'd0}, 16'h2A00, 8'h03, 8'h04, '{32'd7, 8'h00, 1'b0, 8'h07}};
    vecs[2] = '{1'b1, 32'd5, {32'd5, 32'd5}, 16'hBBAA, 8'h80, 8'h80, '{32'd5, 8'hAA, 1'b1, 8'h00}};
    vecs[3] = '{1'b0, 32'd9, {32'd9, 32'd5}, 16'h1122, 8'h12, 8'h34, '{32'd5, 8'h22, 1'b1, 8'h46}};
    vecs[4] = '{1'b0, 32'd9, {32'd5, 32'd3}, 16'h7766, 8'hF0, 8'h0F, '{32'd5, 8'h77, 1'b1, 8'hFF}};
    vecs[5] = '{1'b1, 32'd3, {32'd5, 32'd3}, 16'h7766, 8'h01, 8'h01, '{32'd3, 8'h66, 1'b1, 8'h02}};
    vecs[6] = '{1'b1, 32'd0, {32'd0, 32'd0}, 16'hCCDD, 8'h7F, 8'h01, '{32'd0, 8'hDD, 1'b1, 8'h80}};

    // Reset with pair 0 carrying id 0.
    rst = 1'b1; bb_id = 32'd0; bb_commit = 1'b0;
    phi_s = {32'd1, 32'd0}; phi_in = 16'h2A00; add_in0 = 8'd3; add_in1 = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_last_block", last_block, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    chk("reset_phi_out", {24'd0, phi_out}, 32'h00);
    chk("reset_phi_hit", {31'd0, phi_hit}, 32'd1);
    chk("reset_add_out", {24'd0, add_out}, 32'd7);

    // Before the edge, a commit must not reach the selector.
    @(negedge clk); bb_id = 32'd1; bb_commit = 1'b1;
    #1;
    chk("precommit_last_block", last_block, 32'd0);
    chk("precommit_phi_out", {24'd0, phi_out}, 32'h00);
    bb_commit = 1'b0;

    // Table vectors through the scoreboard.
    foreach (vecs[i]) begin
      @(negedge clk);
      bb_commit = vecs[i].commit; bb_id = vecs[i].id;
      phi_s = vecs[i].s; phi_in = vecs[i].pin;
      add_in0 = vecs[i].a0; add_in1 = vecs[i].a1;
      exp_q.push_back(vecs[i].e);
      @(posedge clk);
      #1 bb_commit = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
      pop_check(i);
    end

    // Reset and commit in the same cycle: reset wins.
    @(negedge clk);
    bb_commit = 1'b1; bb_id = 32'd9; rst = 1'b1;
    phi_s = {32'd9, 32'd0}; phi_in = 16'h5544;
    @(posedge clk);
    #1 rst = 1'b0; bb_commit = 1'b0;
    chk("rst_vs_commit_last_block", last_block, 32'd0);
    repeat (LAT) @(posedge clk);
    #1;
    chk("rst_vs_commit_phi_out", {24'd0, phi_out}, 32'h44);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
